bit_frame_tx: RTL
=================

// Module: bit_frame_tx
// PURPOSE
//   Upstream serializer for the start-bit sampling FSM stage. Accepts parallel
//   words over a valid/ready handshake and sends each data bit as a 3-cycle
//   frame on ser_out: start (1), gap (0), data (d). The downstream FSM detects
//   the start bit and samples the data bit two cycles later. A one-entry
//   holding register lets the next word be accepted while the current word is
//   being sent.
// PARAMETERS
//   DATA_W      8   word width in bits, >= 1
//   GAP_CYCLES  0   idle cycles (ser_out=0) inserted after each word, 0..255
//   LSB_FIRST   0   1: send bit 0 first; 0: send bit DATA_W-1 first
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high; clears all state
//   s_valid    in   1       upstream word valid
//   s_ready    out  1       block can accept a word; equals ~hold_valid
//   s_data     in   DATA_W  word; captured on s_valid & s_ready at clk edge
//   ser_out    out  1       serial frame stream to the sampling FSM (registered)
//   data_phase out  1       high during every DATA cycle (ser_out = data bit)
//   word_done  out  1       1-cycle pulse during the last DATA cycle of a word
//   busy       out  1       state != IDLE or hold_valid
// BEHAVIOUR
//   Reset values: ser_out=0, data_phase=0, word_done=0, busy=0, s_ready=1,
//   hold_valid=0, state=IDLE, counters=0. Reset takes effect immediately.
//   Handshake: a word transfers on a clk edge with s_valid & s_ready and is
//   written into the hold register. s_ready falls the next cycle. s_data must
//   not be sampled at any other time.
//   States and transitions (one step per clk edge):
//     IDLE : hold_valid -> move hold to shifter, clear hold_valid, go to START
//     START: ser_out=1 -> GAP
//     GAP  : ser_out=0 -> DATA
//     DATA : ser_out=current bit, data_phase=1
//            bits left -> shift, go to START
//            last bit  -> word_done=1. If GAP_CYCLES>0, go to PAUSE.
//                         Else, if hold_valid, reload and go to START.
//                         Else go to IDLE.
//     PAUSE: ser_out=0 for exactly GAP_CYCLES cycles. Then, if hold_valid,
//            reload and go to START; else go to IDLE.
//   ser_out, data_phase and word_done are flops loaded with the value of the
//   next state, so they carry no combinational glitches.
//   Latency: handshake at edge k with the block idle -> hold loaded at k ->
//   IDLE->START at k+1 -> ser_out=1 in the cycle after edge k+1.
//   Word length: 3*DATA_W cycles plus GAP_CYCLES. With GAP_CYCLES=0 and the
//   hold register full, words run back-to-back with no idle cycle.
//   A hold->shifter move clears hold_valid. s_ready therefore rises the cycle
//   after the move. Accept and move can never fall on the same edge.
//   Bit counter width: $clog2(DATA_W+1). It must not wrap during a word.
//   The pause counter is 8 bits.
//   Bit order follows LSB_FIRST. The shifter holds a private copy of the
//   word, so later changes on s_data do not affect a word being sent.
//   s_valid held high while s_ready=0: no capture, no duplicate accept.
//   Reset in mid-word: the word and the hold contents are discarded and
//   ser_out drops to 0 at once. After release, the block is in IDLE with
//   s_ready=1.
// TESTING
//   1 DATA_W=4, GAP=0, send 4'b1010 -> ser_out 1,0,1,1,0,0,1,0,1,1,0,0;
//     word_done in cycle 12. The attached sampling FSM gives Dout=1 in
//     cycles 3 and 9.
//   2 Back-to-back 4'hA then 4'h5, s_valid held high -> second accept the cycle
//     after the first hold->shifter move; 24 contiguous frame cycles with no
//     idle cycle between words.
//   3 GAP_CYCLES=2, two words -> exactly two ser_out=0 cycles between the last
//     DATA of word 1 and the START of word 2.
//   4 LSB_FIRST=1, send 4'b0001 -> data bits 1,0,0,0.
//   5 Assert reset during the GAP of bit 2 -> ser_out=0, busy=0, s_ready=1 at
//     once. Send 4'hF after release -> complete word, all data bits 1.
//   6 Hold s_valid high with s_ready=0 and change s_data -> only the value
//     present on the accept edge is sent; no extra word is sent.

Source files
------------

// File: rtl/bit_frame_tx.sv
// bit_frame_tx
//   Serializer feeding a start-bit sampling FSM. A word is accepted over a
//   valid/ready handshake into a one-entry hold register. Each data bit is
//   then sent as a 3-cycle frame on ser_out: start (1), gap (0), data (d).
//   An optional run of idle cycles can follow each word.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   s_valid    in   upstream word valid
//   s_ready    out  block can accept a word (hold register empty)
//   s_data     in   DATA_W-bit word, captured on s_valid & s_ready
//   ser_out    out  registered serial frame stream
//   data_phase out  high in every DATA cycle
//   word_done  out  one-cycle pulse during the last DATA cycle of a word
//   busy       out  a word is being sent or is waiting in the hold register
module bit_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0,
  parameter int LSB_FIRST  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              ser_out,
  output logic              data_phase,
  output logic              word_done,
  output logic              busy
);

  // Sized to hold DATA_W itself so it never wraps within a word.
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, GAP, DATA, PAUSE} state_t;

  state_t            state;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        pause_cnt;

  logic              cur_bit;
  logic              last_bit;
  logic              word_end;
  logic              load_now;
  logic [DATA_W-1:0] shift_next;

  assign cur_bit    = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[DATA_W-1];
  assign shift_next = (LSB_FIRST != 0) ? (shift_reg >> 1) : (shift_reg << 1);
  assign last_bit   = (bit_cnt == CNT_W'(1));

  // word_end marks an edge where the shifter becomes free: idle, the last DATA
  // cycle when no pause follows, or the final pause cycle.
  assign word_end = (state == IDLE)
                 || (state == DATA && last_bit && GAP_CYCLES == 0)
                 || (state == PAUSE && pause_cnt <= 8'd1);
  assign load_now = word_end && hold_valid;

  assign s_ready = ~hold_valid;
  assign busy    = (state != IDLE) || hold_valid;

  // Outputs are loaded with the value belonging to the next state, so they
  // are plain flops aligned with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      pause_cnt  <= '0;
      ser_out    <= 1'b0;
      data_phase <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      ser_out    <= 1'b0;
      data_phase <= 1'b0;
      word_done  <= 1'b0;

      // Accept requires an empty hold register and a move requires a full
      // one, so these two writes of hold_valid never coincide.
      if (s_valid && !hold_valid) begin
        hold_data  <= s_data;
        hold_valid <= 1'b1;
      end

      if (load_now) begin
        shift_reg  <= hold_data;
        bit_cnt    <= CNT_W'(DATA_W);
        hold_valid <= 1'b0;
        state      <= START;
        ser_out    <= 1'b1;
      end else if (word_end) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        pause_cnt <= '0;
      end else begin
        case (state)
          START: state <= GAP;
          GAP: begin
            state      <= DATA;
            ser_out    <= cur_bit;
            data_phase <= 1'b1;
            word_done  <= last_bit;
          end
          DATA: begin
            if (!last_bit) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt - CNT_W'(1);
              state     <= START;
              ser_out   <= 1'b1;
            end else begin
              // Only reached when a pause follows the word.
              state     <= PAUSE;
              pause_cnt <= 8'(GAP_CYCLES);
              bit_cnt   <= '0;
            end
          end
          PAUSE:   pause_cnt <= pause_cnt - 8'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
